// File: rtl/repetition_serial_decoder.sv
`default_nettype none
// ============================================================================
// Module      : repetition_serial_decoder
// Description : Receive-side decoder for a bit-serial repetition-coded link.
//               Each data bit arrives REPETITION_FACTOR times back-to-back
//               (LSB first). Each group is majority-voted. DATA_WIDTH
//               decoded bits are packed into a word, which is presented on a
//               valid/ready output with a per-bit disagreement mask.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DATA_WIDTH        decoded word width (>= 1)
//   REPETITION_FACTOR copies per data bit (>= 1, odd recommended)
// Ports:
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   bit_in          serial coded bit
//   bit_valid       bit_in is valid
//   bit_ready       decoder accepts bit_in this cycle (high while collecting)
//   sync_clr        discard any partially received word (collect phase only)
//   data_out        decoded word
//   data_valid      data_out / error_bits / error_corrected are valid
//   data_ready      downstream accepts the word
//   error_bits      per-bit mask, 1 = copies in that group disagreed
//   error_corrected OR-reduction of error_bits
//   err_count       (REPETITION_SERIAL_DECODER_ERR_COUNT_EN only) saturating
//                   running total of flagged bits; cleared by rst_n only
// Optional feature macro: REPETITION_SERIAL_DECODER_ERR_COUNT_EN
// ============================================================================
module repetition_serial_decoder #(
    parameter int DATA_WIDTH        = 8,
    parameter int REPETITION_FACTOR = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    output logic                  bit_ready,
    input  logic                  sync_clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic [DATA_WIDTH-1:0] error_bits,
    output logic                  error_corrected
`ifdef REPETITION_SERIAL_DECODER_ERR_COUNT_EN
    ,
    output logic [15:0]           err_count
`endif
);

    // Counter widths; a counter never narrower than one bit.
    localparam int c_ONES_W = $clog2(REPETITION_FACTOR + 1);
    localparam int c_REP_W  = (REPETITION_FACTOR > 1) ? $clog2(REPETITION_FACTOR) : 1;
    localparam int c_IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [c_REP_W-1:0]  c_REP_LAST  = c_REP_W'(REPETITION_FACTOR - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(DATA_WIDTH - 1);
    localparam logic [c_ONES_W-1:0] c_HALF      = c_ONES_W'(REPETITION_FACTOR / 2);
    localparam logic [c_ONES_W-1:0] c_ALL       = c_ONES_W'(REPETITION_FACTOR);

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [c_REP_W-1:0]    r_rep_cnt;
    logic [c_ONES_W-1:0]   r_ones_cnt;
    logic [c_IDX_W-1:0]    r_bit_idx;
    logic [DATA_WIDTH-1:0] r_word;
    logic [DATA_WIDTH-1:0] r_mask;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic [DATA_WIDTH-1:0] r_err_bits;
    logic                  r_err_corr;
    logic                  r_data_valid;

    logic                  w_accept;
    logic                  w_last_rep;
    logic                  w_last_bit;
    logic [c_ONES_W-1:0]   w_total;
    logic                  w_dec_bit;
    logic                  w_mask_bit;
    logic [DATA_WIDTH-1:0] w_word_next;
    logic [DATA_WIDTH-1:0] w_mask_next;

    // ------------------------------------------------------------------
    // Group vote: the closing copy is folded in combinationally so the
    // decision is made on the same edge that accepts the last copy.
    // ------------------------------------------------------------------
    always_comb begin
        w_accept    = bit_valid && (r_state == S_COLLECT);
        w_last_rep  = (r_rep_cnt == c_REP_LAST);
        w_last_bit  = (r_bit_idx == c_IDX_LAST);
        w_total     = r_ones_cnt + c_ONES_W'(bit_in);
        // Even factor ties (total == half) fall on the "not greater" side -> 0.
        w_dec_bit   = (w_total > c_HALF);
        w_mask_bit  = (w_total != '0) && (w_total != c_ALL);
        w_word_next = r_word;
        w_mask_next = r_mask;
        w_word_next[r_bit_idx] = w_dec_bit;
        w_mask_next[r_bit_idx] = w_mask_bit;
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_COLLECT: begin
                // sync_clr overrides a word close on the same edge.
                if (w_accept && !sync_clr && w_last_rep && w_last_bit) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (data_ready) begin
                    w_state_next = S_COLLECT;
                end
            end
            default: w_state_next = S_COLLECT;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: counters, partial word, output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rep_cnt    <= '0;
            r_ones_cnt   <= '0;
            r_bit_idx    <= '0;
            r_word       <= '0;
            r_mask       <= '0;
            r_data_out   <= '0;
            r_err_bits   <= '0;
            r_err_corr   <= 1'b0;
            r_data_valid <= 1'b0;
        end else if (r_state == S_COLLECT) begin
            if (sync_clr) begin
                r_rep_cnt  <= '0;
                r_ones_cnt <= '0;
                r_bit_idx  <= '0;
                r_word     <= '0;
                r_mask     <= '0;
            end else if (w_accept) begin
                if (w_last_rep) begin
                    r_rep_cnt  <= '0;
                    r_ones_cnt <= '0;
                    if (w_last_bit) begin
                        // Word complete: publish and restart the assembly.
                        r_bit_idx    <= '0;
                        r_word       <= '0;
                        r_mask       <= '0;
                        r_data_out   <= w_word_next;
                        r_err_bits   <= w_mask_next;
                        r_err_corr   <= |w_mask_next;
                        r_data_valid <= 1'b1;
                    end else begin
                        r_bit_idx <= r_bit_idx + c_IDX_W'(1);
                        r_word    <= w_word_next;
                        r_mask    <= w_mask_next;
                    end
                end else begin
                    r_rep_cnt  <= r_rep_cnt + c_REP_W'(1);
                    r_ones_cnt <= w_total;
                end
            end
        end else if (data_ready) begin
            // Held word consumed; data_out/error_bits keep their last value.
            r_data_valid <= 1'b0;
        end
    end

`ifdef REPETITION_SERIAL_DECODER_ERR_COUNT_EN
    logic [15:0] r_err_count;
    logic [16:0] w_err_sum;

    always_comb begin
        w_err_sum = {1'b0, r_err_count};
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_err_sum = w_err_sum + 17'(w_mask_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (w_accept && !sync_clr && w_last_rep && w_last_bit) begin
            r_err_count <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        end
    end

    assign err_count = r_err_count;
`endif

    assign bit_ready       = (r_state == S_COLLECT);
    assign data_out        = r_data_out;
    assign data_valid      = r_data_valid;
    assign error_bits      = r_err_bits;
    assign error_corrected = r_err_corr;

endmodule
`default_nettype wire

// File: tb/tb_repetition_serial_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_repetition_serial_decoder
// Description : Self-checking bench for repetition_serial_decoder with
//               default parameters (8-bit words, factor 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_repetition_serial_decoder;

    localparam int DW = 8;
    localparam int RF = 3;
    localparam int NC = DW * RF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bit_in;
    logic          bit_valid;
    logic          bit_ready;
    logic          sync_clr;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          data_ready;
    logic [DW-1:0] error_bits;
    logic          error_corrected;
`ifdef REPETITION_SERIAL_DECODER_ERR_COUNT_EN
    logic [15:0]   err_count;
    int            exp_err_count = 0;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    repetition_serial_decoder #(
        .DATA_WIDTH       (DW),
        .REPETITION_FACTOR(RF)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bit_in         (bit_in),
        .bit_valid      (bit_valid),
        .bit_ready      (bit_ready),
        .sync_clr       (sync_clr),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .error_bits     (error_bits),
        .error_corrected(error_corrected)
`ifdef REPETITION_SERIAL_DECODER_ERR_COUNT_EN
        ,
        .err_count      (err_count)
`endif
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [NC-1:0] flips;
        logic [DW-1:0] exp_data;
        logic [DW-1:0] exp_err;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: build the coded stream and vote each group by counting ones.
    function automatic void model(input logic [DW-1:0] d, input logic [NC-1:0] fl,
                                  output logic [NC-1:0] coded,
                                  output logic [DW-1:0] ed, output logic [DW-1:0] ee);
        int cnt;
        for (int i = 0; i < DW; i++) begin
            cnt = 0;
            for (int k = 0; k < RF; k++) begin
                coded[i*RF+k] = d[i] ^ fl[i*RF+k];
                cnt += int'(coded[i*RF+k]);
            end
            ed[i] = (cnt > RF / 2);
            ee[i] = (cnt != 0) && (cnt != RF);
        end
    endfunction

    // Send a coded stream LSB first; optionally insert random idle gaps.
    task automatic send_coded(input logic [NC-1:0] coded, input int nbits, input bit gaps);
        int guard;
        for (int j = 0; j < nbits; j++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    bit_valid = 1'b0;
                    bit_in    = 1'($urandom);
                    tick();
                end
            end
            bit_in    = coded[j];
            bit_valid = 1'b1;
            guard     = 0;
            while (!bit_ready && guard < 100) begin
                tick();
                guard++;
            end
            if (guard >= 100) chk("bit_ready_timeout", 32'(bit_ready), 32'd1);
            tick();
        end
        bit_valid = 1'b0;
    endtask

    // Called #1 after the edge that accepted the final coded bit.
    task automatic check_word(input string tag, input logic [DW-1:0] ed,
                              input logic [DW-1:0] ee, input int hold);
        chk({tag, "_dv_rise"}, 32'(data_valid), 32'd1);
        chk({tag, "_data"}, 32'(data_out), 32'(ed));
        chk({tag, "_err"}, 32'(error_bits), 32'(ee));
        chk({tag, "_corr"}, 32'(error_corrected), 32'(|ee));
`ifdef REPETITION_SERIAL_DECODER_ERR_COUNT_EN
        exp_err_count = exp_err_count + $countones(ee);
        if (exp_err_count > 65535) exp_err_count = 65535;
        chk({tag, "_errcnt"}, 32'(err_count), 32'(exp_err_count));
`endif
        for (int h = 0; h < hold; h++) begin
            // Junk on the input side and a sync_clr must not disturb HOLD.
            bit_valid = 1'b1;
            bit_in    = 1'($urandom);
            sync_clr  = (h == 1);
            tick();
            chk({tag, "_hold_dv"}, 32'(data_valid), 32'd1);
            chk({tag, "_hold_brdy"}, 32'(bit_ready), 32'd0);
            chk({tag, "_hold_data"}, 32'({error_bits, data_out}), 32'({ee, ed}));
        end
        bit_valid  = 1'b0;
        sync_clr   = 1'b0;
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        chk({tag, "_dv_drop"}, 32'(data_valid), 32'd0);
        chk({tag, "_brdy_back"}, 32'(bit_ready), 32'd1);
    endtask

    vec_t          vecs[5];
    logic [NC-1:0] coded;
    logic [DW-1:0] ed;
    logic [DW-1:0] ee;
    logic [NC-1:0] ones_stream;

    initial begin
        rst_n      = 1'b0;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        sync_clr   = 1'b0;
        data_ready = 1'b0;
        ones_stream = '1;

        // data, flips, expected data, expected mask (hand-derived)
        vecs[0] = '{8'hA5, 24'h000000, 8'hA5, 8'h00};  // clean
        vecs[1] = '{8'h3C, 24'h800401, 8'h3C, 8'h89};  // one copy flipped in bits 0,3,7
        vecs[2] = '{8'h00, 24'h0000C0, 8'h04, 8'h04};  // 2 of 3 copies of bit 2 -> miscorrect
        vecs[3] = '{8'hFF, 24'h038000, 8'hDF, 8'h00};  // all copies of bit 5 flipped
        vecs[4] = '{8'h5A, 24'h000000, 8'h5A, 8'h00};

        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_dv", 32'(data_valid), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_err", 32'(error_bits), 32'd0);
        chk("rst_corr", 32'(error_corrected), 32'd0);
        chk("rst_brdy", 32'(bit_ready), 32'd1);
`ifdef REPETITION_SERIAL_DECODER_ERR_COUNT_EN
        chk("rst_errcnt", 32'(err_count), 32'd0);
`endif

        // Table vectors: back-to-back, no backpressure beyond the handshake cycle.
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < DW; i++)
                for (int k = 0; k < RF; k++)
                    coded[i*RF+k] = vecs[v].data[i] ^ vecs[v].flips[i*RF+k];
            send_coded(coded, NC, 1'b0);
            check_word($sformatf("tab%0d", v), vecs[v].exp_data, vecs[v].exp_err, 0);
        end

        // Backpressure: hold data_ready low for 5 cycles.
        model(8'hC3, 24'h000010, coded, ed, ee);
        send_coded(coded, NC, 1'b0);
        check_word("bp", ed, ee, 5);

        // sync_clr mid-word, with a valid bit presented on the same cycle.
        send_coded(ones_stream, 10, 1'b0);
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        sync_clr  = 1'b1;
        tick();
        sync_clr  = 1'b0;
        bit_valid = 1'b0;
        model(8'h5A, '0, coded, ed, ee);
        send_coded(coded, NC, 1'b0);
        check_word("sclr", 8'h5A, 8'h00, 0);

        // Reset mid-word: outputs return to zero, then a clean decode.
        send_coded(ones_stream, 10, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_dv", 32'(data_valid), 32'd0);
        chk("mrst_data", 32'(data_out), 32'd0);
        chk("mrst_err", 32'(error_bits), 32'd0);
        chk("mrst_corr", 32'(error_corrected), 32'd0);
`ifdef REPETITION_SERIAL_DECODER_ERR_COUNT_EN
        exp_err_count = 0;
        chk("mrst_errcnt", 32'(err_count), 32'd0);
`endif
        send_coded(coded, NC, 1'b0);
        check_word("mrst", 8'h5A, 8'h00, 0);

        // Randomized words with random flips, idle gaps and backpressure.
        for (int r = 0; r < 40; r++) begin
            logic [NC-1:0] fl;
            fl = '0;
            for (int j = 0; j < NC; j++) fl[j] = ($urandom_range(0, 5) == 0);
            model(DW'($urandom), fl, coded, ed, ee);
            send_coded(coded, NC, 1'b1);
            check_word($sformatf("rnd%0d", r), ed, ee, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
